// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared CPU types used by the RAM arbiter and its neighbours.
//   word_t      - 32-bit machine word
//   ramstate_t  - RAM status returned by the RAM model
//   arbstate_t  - arbiter FSM states
//   arbown_t    - registered transfer owner {core index, is_dcache}
//   next_core() - round-robin successor of a core index
package ram_arbiter_pkg;

  localparam int CPUS   = 2;
  localparam int CORE_W = (CPUS > 1) ? $clog2(CPUS) : 1;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_SERVE
  } arbstate_t;

  typedef struct packed {
    logic [CORE_W-1:0] core;
    logic              isd;
  } arbown_t;

  // Successor of core c in a ring of ncpu cores.
  function automatic logic [CORE_W-1:0] next_core(input logic [CORE_W-1:0] c,
                                                  input int               ncpu);
    if (int'(c) == ncpu - 1) return '0;
    else                     return c + 1'b1;
  endfunction

endpackage

// File: rtl/ram_arbiter_select.sv
// arb_select: combinational requester picker for ram_arbiter.
// Ports:
//   ireq  [CPUS]  icache request per core
//   dreq  [CPUS]  dcache request per core (read or write)
//   ptr           core at which the search starts
//   valid         some requester is pending
//   own           chosen owner {core, isd}; dcache wins within a core
module arb_select
  import ram_arbiter_pkg::*;
#(
  parameter int CPUS = ram_arbiter_pkg::CPUS
) (
  input  logic [CPUS-1:0]   ireq,
  input  logic [CPUS-1:0]   dreq,
  input  logic [CORE_W-1:0] ptr,
  output logic              valid,
  output arbown_t           own
);

  always_comb begin
    logic [CORE_W-1:0] idx;
    valid = 1'b0;
    own   = '0;
    idx   = '0;
    // Walk the ring starting at ptr; the first core with any request wins.
    for (int i = 0; i < CPUS; i++) begin
      idx = CORE_W'((int'(ptr) + i) % CPUS);
      if (!valid && (dreq[idx] || ireq[idx])) begin
        valid    = 1'b1;
        own.core = idx;
        own.isd  = dreq[idx];
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single RAM port among the icache and dcache of every
// core. One transfer at a time; the owner is latched in ARB_IDLE and served
// until the RAM answers ACCESS.
// Build option: define RAM_ARB_ROUND_ROBIN_EN for round-robin core selection;
// otherwise the lowest-numbered requesting core wins (no pointer register).
// Ports:
//   CLK, RST              clock, asynchronous active-high reset
//   iREN/iaddr/iwait      icache request, address, stall per core
//   iload                 icache read data (copy of ramload)
//   dREN/dWEN/daddr/dstore/dwait  dcache request, address, data, stall per core
//   dload                 dcache read data (copy of ramload)
//   ramREN/ramWEN/ramaddr/ramstore  RAM command
//   ramload, ramstate     RAM read data and status
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int CPUS = ram_arbiter_pkg::CPUS
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [CPUS-1:0]       iREN,
  input  word_t [CPUS-1:0]      iaddr,
  output logic [CPUS-1:0]       iwait,
  output word_t                 iload,
  input  logic [CPUS-1:0]       dREN,
  input  logic [CPUS-1:0]       dWEN,
  input  word_t [CPUS-1:0]      daddr,
  input  word_t [CPUS-1:0]      dstore,
  output logic [CPUS-1:0]       dwait,
  output word_t                 dload,
  output logic                  ramREN,
  output logic                  ramWEN,
  output word_t                 ramaddr,
  output word_t                 ramstore,
  input  word_t                 ramload,
  input  ramstate_t             ramstate
);

  arbstate_t         state;
  arbown_t           owner;
  logic [CORE_W-1:0] sel_ptr;
  logic              sel_valid;
  arbown_t           sel_own;
  logic              serving;
  logic              done;
  logic              owner_live;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic [CORE_W-1:0] ptr;
  assign sel_ptr = ptr;
`else
  assign sel_ptr = '0;
`endif

  arb_select #(.CPUS(CPUS)) u_select (
    .ireq  (iREN),
    .dreq  (dREN | dWEN),
    .ptr   (sel_ptr),
    .valid (sel_valid),
    .own   (sel_own)
  );

  assign serving    = (state == ARB_SERVE);
  assign done       = serving && (ramstate == ACCESS);
  // Owner still presenting its request; a drop mid-serve aborts the transfer.
  assign owner_live = owner.isd ? (dREN[owner.core] | dWEN[owner.core])
                                : iREN[owner.core];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ARB_IDLE;
      owner <= '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      ptr   <= '0;
`endif
    end else begin
      case (state)
        ARB_IDLE: begin
          if (sel_valid) begin
            owner <= sel_own;
            state <= ARB_SERVE;
          end
        end
        ARB_SERVE: begin
          if (done) begin
            state <= ARB_IDLE;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            ptr   <= next_core(owner.core, CPUS);
`endif
          end else if (!owner_live) begin
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // RAM command and stall muxing, driven straight from the owner's inputs.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = '1;
    if (serving) begin
      if (owner.isd) begin
        // A write wins when read and write are both requested.
        ramWEN   = dWEN[owner.core];
        ramREN   = dREN[owner.core] & ~dWEN[owner.core];
        ramaddr  = daddr[owner.core];
        ramstore = dstore[owner.core];
        if (done) dwait[owner.core] = 1'b0;
      end else begin
        ramREN  = 1'b1;
        ramaddr = iaddr[owner.core];
        if (done) iwait[owner.core] = 1'b0;
      end
    end
  end

  assign iload = ramload;
  assign dload = ramload;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [1:0]   iREN = '0;
  word_t [1:0]  iaddr = '0;
  logic [1:0]   iwait;
  word_t        iload;
  logic [1:0]   dREN = '0;
  logic [1:0]   dWEN = '0;
  word_t [1:0]  daddr = '0;
  word_t [1:0]  dstore = '0;
  logic [1:0]   dwait;
  word_t        dload;
  logic         ramREN;
  logic         ramWEN;
  word_t        ramaddr;
  word_t        ramstore;
  word_t        ramload = '0;
  ramstate_t    ramstate = FREE;

  ram_arbiter #(.CPUS(2)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic  re;
    logic  we;
    word_t addr;
    word_t data;
  } op_t;

  // Port p: core = p/2, dcache when p is odd.
  op_t pend [4][$];
  op_t expq [4][$];
  bit  active [4];
  bit  done_f [4];
  int  grants [$];
  int  gcyc [$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int busy_n = 0;
  bit use_err = 1'b0;
  int rcnt = 0;
  bit prev_vld = 1'b0;
  logic [65:0] prev_cmd = '0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic word_t data_of(input word_t a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  always @(posedge CLK) cyc++;

  // RAM model: busy_n BUSY (or ERROR) cycles, then ACCESS.
  always @(posedge CLK) begin
    #2;
    if (ramREN || ramWEN) begin
      if (rcnt < busy_n) begin
        ramstate = use_err ? ERROR : BUSY;
        ramload  = '0;
      end else begin
        ramstate = ACCESS;
        ramload  = ramWEN ? 32'h0 : data_of(ramaddr);
      end
      rcnt++;
    end else begin
      ramstate = FREE;
      ramload  = '0;
      rcnt     = 0;
    end
  end

  // Requester agents: present queued ops, retire them once completed.
  always @(posedge CLK) begin
    op_t op;
    #1;
    for (int p = 0; p < 4; p++) begin
      if (done_f[p]) begin
        done_f[p] = 1'b0;
        active[p] = 1'b0;
        if (p % 2 == 1) begin
          dREN[p/2] = 1'b0; dWEN[p/2] = 1'b0; daddr[p/2] = '0; dstore[p/2] = '0;
        end else begin
          iREN[p/2] = 1'b0; iaddr[p/2] = '0;
        end
      end
      if (!active[p] && pend[p].size() > 0) begin
        op = pend[p].pop_front();
        expq[p].push_back(op);
        active[p] = 1'b1;
        if (p % 2 == 1) begin
          dREN[p/2] = op.re; dWEN[p/2] = op.we; daddr[p/2] = op.addr; dstore[p/2] = op.data;
        end else begin
          iREN[p/2] = 1'b1; iaddr[p/2] = op.addr;
        end
      end
    end
  end

  // Monitor: wait discipline, command stability, completions vs scoreboard.
  always @(negedge CLK) begin
    logic        cmd_on;
    logic [65:0] cmd;
    logic        low;
    op_t         op;
    cmd_on = ramREN || ramWEN;
    cmd    = {ramREN, ramWEN, ramaddr, ramstore};
    if (!(cmd_on && ramstate == ACCESS))
      check("wait_hold", {76'h0, iwait, dwait}, 80'hF);
    else
      check("one_grant", 80'($countones(~{iwait, dwait}) <= 1), 80'h1);
    if (cmd_on && prev_vld) check("cmd_stable", 80'(cmd), 80'(prev_cmd));
    prev_vld = cmd_on && (ramstate != ACCESS);
    prev_cmd = cmd;
    for (int p = 0; p < 4; p++) begin
      low = (p % 2 == 1) ? !dwait[p/2] : !iwait[p/2];
      if (low) begin
        if (expq[p].size() == 0) begin
          check("unexpected_done", 80'(p), 80'd99);
        end else begin
          op = expq[p].pop_front();
          grants.push_back(p);
          gcyc.push_back(cyc);
          check("done_addr", 80'(ramaddr), 80'(op.addr));
          if (p % 2 == 1) begin
            check("done_wen", 80'(ramWEN), 80'(op.we));
            check("done_ren", 80'(ramREN), 80'(op.re & ~op.we));
            if (op.we) check("done_store", 80'(ramstore), 80'(op.data));
            else       check("dload", 80'(dload), 80'(data_of(op.addr)));
          end else begin
            check("done_iren", 80'(ramREN), 80'h1);
            check("iload", 80'(iload), 80'(data_of(op.addr)));
          end
        end
        done_f[p] = 1'b1;
      end
    end
  end

  task automatic drain(input int budget);
    bit busy;
    busy = 1'b1;
    for (int i = 0; i < budget && busy; i++) begin
      @(negedge CLK);
      busy = 1'b0;
      for (int p = 0; p < 4; p++)
        if (pend[p].size() > 0 || expq[p].size() > 0 || active[p]) busy = 1'b1;
    end
    check("drain", 80'(busy), 80'h0);
  endtask

  function automatic op_t mk(input logic re, input logic we, input word_t a, input word_t d);
    op_t o;
    o.re = re; o.we = we; o.addr = a; o.data = d;
    return o;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    int k;
    int exp_core;

    // Reset state
    #1 RST = 1'b1;
    @(negedge CLK);
    check("rst_ren", 80'(ramREN), 80'h0);
    check("rst_wen", 80'(ramWEN), 80'h0);
    check("rst_addr", 80'(ramaddr), 80'h0);
    check("rst_store", 80'(ramstore), 80'h0);
    check("rst_waits", {76'h0, iwait, dwait}, 80'hF);
    RST = 1'b0;
    @(negedge CLK);

    // Single icache read, 2 BUSY cycles then ACCESS
    busy_n = 2;
    k = cyc;
    g0 = grants.size();
    pend[0].push_back(mk(1'b1, 1'b0, 32'h40, 32'h0));
    @(posedge CLK);
    @(negedge CLK);
    check("t1_idle_ren", 80'(ramREN), 80'h0);
    @(negedge CLK);
    check("t1_ren", 80'(ramREN), 80'h1);
    check("t1_addr", 80'(ramaddr), 80'h40);
    check("t1_iwait", 80'(iwait[0]), 80'h1);
    drain(50);
    check("t1_count", 80'(grants.size()), 80'(g0 + 1));
    if (gcyc.size() > g0) check("t1_latency", 80'(gcyc[g0] - k), 80'd4);

    // Dcache write beats icache read on the same core
    busy_n = 0;
    g0 = grants.size();
    pend[3].push_back(mk(1'b0, 1'b1, 32'h100, 32'h5));
    pend[2].push_back(mk(1'b1, 1'b0, 32'h200, 32'h0));
    drain(50);
    check("t2_count", 80'(grants.size()), 80'(g0 + 2));
    if (grants.size() >= g0 + 2) begin
      check("t2_first", 80'(grants[g0]), 80'd3);
      check("t2_second", 80'(grants[g0 + 1]), 80'd2);
      check("t2_gap", 80'(gcyc[g0 + 1] - gcyc[g0]), 80'd2);
    end

    // dREN and dWEN together: write wins
    pend[1].push_back(mk(1'b1, 1'b1, 32'h300, 32'h77));
    @(posedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    check("t4_wen", 80'(ramWEN), 80'h1);
    check("t4_ren", 80'(ramREN), 80'h0);
    check("t4_store", 80'(ramstore), 80'h77);
    drain(50);

    // ERROR for 3 cycles then ACCESS
    busy_n = 3;
    use_err = 1'b1;
    k = cyc;
    g0 = grants.size();
    pend[2].push_back(mk(1'b1, 1'b0, 32'h440, 32'h0));
    drain(50);
    check("t5_count", 80'(grants.size()), 80'(g0 + 1));
    if (gcyc.size() > g0) check("t5_latency", 80'(gcyc[g0] - k), 80'd5);
    use_err = 1'b0;

    // Reset in the middle of a serve
    busy_n = 20;
    pend[0].push_back(mk(1'b1, 1'b0, 32'h500, 32'h0));
    @(posedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    check("t6_pre_ren", 80'(ramREN), 80'h1);
    #1 RST = 1'b1;
    #1;
    check("t6_ren", 80'(ramREN), 80'h0);
    check("t6_wen", 80'(ramWEN), 80'h0);
    check("t6_addr", 80'(ramaddr), 80'h0);
    check("t6_waits", {76'h0, iwait, dwait}, 80'hF);
    for (int p = 0; p < 4; p++) begin
      pend[p].delete();
      expq[p].delete();
      active[p] = 1'b0;
      done_f[p] = 1'b0;
    end
    iREN = '0; iaddr = '0;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("t6_idle_ren", 80'(ramREN), 80'h0);
    check("t6_idle_waits", {76'h0, iwait, dwait}, 80'hF);

    // Both cores stream dcache reads
    busy_n = 1;
    g0 = grants.size();
    for (int j = 0; j < 4; j++) begin
      pend[1].push_back(mk(1'b1, 1'b0, 32'h1000 + 32'(j * 4), 32'h0));
      pend[3].push_back(mk(1'b1, 1'b0, 32'h2000 + 32'(j * 4), 32'h0));
    end
    drain(400);
    check("t3_count", 80'(grants.size()), 80'(g0 + 8));
    if (grants.size() >= g0 + 8) begin
      for (int j = 0; j < 8; j++) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
        exp_core = j % 2;
`else
        exp_core = (j < 4) ? 0 : 1;
`endif
        check("t3_order", 80'(grants[g0 + j] / 2), 80'(exp_core));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single RAM port among the instruction and data caches of all cores in the multicore MIPS system. Each cycle in which no transfer is in flight, it picks one pending requester, locks the grant, and drives the RAM with that requester's command until the RAM answers `ACCESS`. It then releases that requester's wait. The block sits between the per-core caches and the RAM model, and uses the shared `word_t` and `ramstate_t` types.

## Interface
- `CPUS`, 2, number of cores; each core has one icache port and one dcache port.
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `iREN`  in  CPUS  icache read request per core.
- `iaddr`  in  CPUS×word_t  icache address per core.
- `iwait`  out  CPUS  icache stall per core; low for exactly the completing cycle.
- `iload`  out  word_t  icache read data, broadcast to all cores (= `ramload`).
- `dREN`, `dWEN`  in  CPUS each  dcache read and write request per core.
- `daddr`, `dstore`  in  CPUS×word_t  dcache address and write data per core.
- `dwait`  out  CPUS  dcache stall per core.
- `dload`  out  word_t  dcache read data, broadcast (= `ramload`).
- `ramREN`, `ramWEN`  out  1  RAM read and write enables.
- `ramaddr`, `ramstore`  out  word_t  RAM address and write data.
- `ramload`  in  word_t  RAM read data.
- `ramstate`  in  ramstate_t  RAM status: `FREE`, `BUSY`, `ACCESS` or `ERROR`.

## Operation
- The state machine has two states, `ARB_IDLE` and `ARB_SERVE`. The registered owner is a pair {core index, is_dcache}.
- **In `ARB_IDLE`:**
  - If any request is pending, the arbiter selects an owner and moves to `ARB_SERVE` on the next edge. Otherwise it stays in `ARB_IDLE`.
  - Within one core, the dcache has priority over the icache.
  - Core selection follows the Configuration section.
- **In `ARB_SERVE`:** the RAM outputs are driven combinationally from the owner's inputs.
  - icache owner: `ramREN=1`, `ramaddr=iaddr`.
  - dcache owner: `ramWEN=dWEN`, `ramREN=dREN & ~dWEN` (a write wins when both are set), `ramaddr=daddr`, `ramstore=dstore`.
- **Completion:** when `ramstate==ACCESS`, the owner's wait is 0 in that same cycle. The state returns to `ARB_IDLE` on the next edge, and the round-robin pointer is updated.
- `BUSY`, `FREE` and `ERROR` are not completion. The arbiter keeps driving the command and holds wait at 1.
- **Owner drops its request mid-serve** (protocol violation): the arbiter returns to `ARB_IDLE` on the next edge without completing. The pointer is not updated.
- **Outputs in `ARB_IDLE`:** `ramREN`, `ramWEN`, `ramaddr` and `ramstore` are 0, and all waits are 1.
- Requests that arrive while a transfer is in `ARB_SERVE` are held off with wait=1. They are considered at the next `ARB_IDLE`.

## Timing
- **Reset (asynchronous):**
  - state = `ARB_IDLE`, owner = {0, 0}, round-robin pointer = core 0.
  - `ramREN=0`, `ramWEN=0`, `ramaddr=0`, `ramstore=0`.
  - Every `iwait` and `dwait` bit = 1.
- **Reset asserted mid-`ARB_SERVE`:** the RAM command drops to 0 immediately (asynchronously). The transfer is lost, and the requester re-presents it after reset.
- **Latency:**
  - Request sampled in `ARB_IDLE` at edge N.
  - RAM command is valid in cycle N+1.
  - The earliest completion is in cycle N+1, if the RAM returns `ACCESS` immediately.
- There is one mandatory `ARB_IDLE` cycle between back-to-back transfers, so peak throughput is one word every 2 cycles.
- **Wait rule:** a wait bit is 0 only in the cycle where (state=`ARB_SERVE`, owner matches, `ramstate==ACCESS`).
- `iload` and `dload` are combinational copies of `ramload`. They are valid only while the matching wait is 0.

## Configuration
- Macro: `RAM_ARB_ROUND_ROBIN_EN`.
- **Defined:** core selection is round-robin. The search starts at the pointer, and after each completion the pointer becomes (owner core + 1) mod `CPUS`.
- **Undefined:** fixed priority, with the lowest-numbered requesting core winning. The pointer register is not built.

## Structure
- **Package additions** (to the shared CPU types package):
  - `arbstate_t` enum with `ARB_IDLE` and `ARB_SERVE`.
  - `arbown_t` packed struct with `core` (`$clog2(CPUS)` bits) and `isd` (1 bit).
- **Sub-module:** `arb_select`, a combinational picker. It takes the request vectors and the pointer, and returns a `valid` flag plus an `arbown_t`.
- **`ram_arbiter` itself** holds the state register, the owner register, the pointer register, and the RAM and wait muxing.

## Test plan
- Single icache read: core 0 sets `iREN=1`, `iaddr=0x40`; RAM gives `BUSY` for 2 cycles, then `ACCESS` with `ramload=0xDEADBEEF`.
  - Required: `ramaddr=0x40` with `ramREN=1` from cycle 1.
  - Required: `iwait[0]=0` and `iload=0xDEADBEEF` only in the `ACCESS` cycle.
- Dcache over icache in the same core: core 1 sets `dWEN=1`, `daddr=0x100`, `dstore=0x5`, and `iREN=1` together.
  - Required: the dcache write is served first (`ramWEN=1`, `ramstore=0x5`).
  - Required: the icache read is served after one `ARB_IDLE` cycle.
- Both cores issue `dREN` continuously, with the macro defined.
  - Required: grants alternate core 0, core 1, core 0, …
  - With the macro undefined: core 0 always wins.
- Both `dREN` and `dWEN` set on core 0.
  - Required: `ramWEN=1` and `ramREN=0`.
- `ramstate=ERROR` for 3 cycles, then `ACCESS`.
  - Required: wait is held at 1 through the `ERROR` cycles, the command is held stable, and completion happens on `ACCESS`.
- `RST` pulsed in the middle of a serve.
  - Required: `ramREN` and `ramWEN` drop to 0 in the same cycle, all waits go to 1, and the state returns to `ARB_IDLE`.
